// File: rtl/frame_sched_pkg.sv
// Shared types and widths for the frame slot scheduler and the host readout path.
package frame_sched_pkg;

  localparam int unsigned ADDR_WIDTH = 30;
  localparam int unsigned CNT_WIDTH  = 5;
  localparam int unsigned DROP_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_ARM     = 2'd2,
    S_CAPTURE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/slot_ring_ctrl.sv
// Ring of frame slots: write/read pointers, occupancy, overwrite drops and slot addresses.
module slot_ring_ctrl
  import frame_sched_pkg::*;
#(
  parameter int unsigned       NUM_SLOTS   = 4,
  parameter int unsigned       ADDR_W      = ADDR_WIDTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'h0080_0000)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic                  i_drop_req,
  input  logic                  i_rd_done,
  output logic                  o_full,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [ADDR_W-1:0]     o_rd_addr,
  output logic [DROP_WIDTH-1:0] o_dropped_count
);

  localparam int unsigned          PTR_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_SLOTS);

  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [CNT_WIDTH-1:0]  r_count, w_count_d;
  logic [ADDR_W-1:0]     r_wr_addr, r_rd_addr;
  logic [DROP_WIDTH-1:0] r_dropped;
  logic                  w_rd_pop, w_drop, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PTR_W-1:0] p);
    return BASE_ADDR + ADDR_W'(p) * FRAME_BYTES;
  endfunction

  // A host release in the same cycle as an overwrite drop takes the place of the drop.
  always_comb begin
    w_rd_pop   = i_rd_done && (r_count != '0);
    w_drop     = i_drop_req && !w_rd_pop && (r_count == FULL_CNT);
    w_pop      = w_rd_pop || w_drop;
    w_wr_ptr_d = i_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_d = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_d  = r_count;
    if (i_push && !w_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (!i_push && w_pop) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_wr_addr <= BASE_ADDR;
      r_rd_addr <= BASE_ADDR;
      r_dropped <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_d;
      r_rd_ptr  <= w_rd_ptr_d;
      r_count   <= w_count_d;
      r_wr_addr <= slot_addr(w_wr_ptr_d);
      r_rd_addr <= slot_addr(w_rd_ptr_d);
      if (w_drop && (r_dropped != '1)) begin
        r_dropped <= r_dropped + 1'b1;
      end
    end
  end

  assign o_full          = (r_count == FULL_CNT);
  assign o_count         = r_count;
  assign o_wr_addr       = r_wr_addr;
  assign o_rd_addr       = r_rd_addr;
  assign o_dropped_count = r_dropped;

endmodule

// File: rtl/frame_slot_scheduler.sv
// Sequences camera captures into a DDR slot ring and hands committed frames to the host.
module frame_slot_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned       NUM_SLOTS      = 4,
  parameter int unsigned       ADDR_W         = ADDR_WIDTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_W-1:0] FRAME_BYTES    = ADDR_W'(32'h0080_0000),
  parameter logic [31:0]       TIMEOUT_CYCLES = 32'd67108864
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_continuous,
  input  logic                  i_overwrite,
  input  logic                  i_capture_req,
  output logic                  o_trigger,
  output logic [ADDR_W-1:0]     o_start_addr,
  input  logic                  i_frame_written,
  output logic                  o_rd_avail,
  output logic [ADDR_W-1:0]     o_rd_addr,
  input  logic                  i_rd_busy,
  input  logic                  i_rd_done,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic [DROP_WIDTH-1:0] o_dropped_count,
  output logic                  o_timeout_err,
  output logic                  o_busy
);

  sched_state_e         r_state, w_state_next;
  logic [31:0]          r_timer;
  logic                 r_pending, r_trigger, r_timeout_err;
  logic [ADDR_W-1:0]    r_start_addr, w_wr_addr;
  logic [CNT_WIDTH-1:0] w_count;
  logic                 w_full, w_push, w_drop_req, w_enter_arm, w_timeout, w_timer_last;

  assign w_timer_last = (r_timer == TIMEOUT_CYCLES - 32'd1);

  slot_ring_ctrl #(
    .NUM_SLOTS   (NUM_SLOTS),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_BYTES (FRAME_BYTES)
  ) u_ring (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_push          (w_push),
    .i_drop_req      (w_drop_req),
    .i_rd_done       (i_rd_done),
    .o_full          (w_full),
    .o_count         (w_count),
    .o_wr_addr       (w_wr_addr),
    .o_rd_addr       (o_rd_addr),
    .o_dropped_count (o_dropped_count)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A capture in flight always runs to commit or timeout, even with enable dropped.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (i_enable && (i_continuous || r_pending)) w_state_next = S_CHECK;
      S_CHECK: begin
        if (!i_enable) begin
          w_state_next = S_IDLE;
        end else if (!w_full || (i_overwrite && !i_rd_busy)) begin
          w_state_next = S_ARM;
        end
      end
      S_ARM:     w_state_next = S_CAPTURE;
      S_CAPTURE: if (i_frame_written || w_timer_last) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_enter_arm   = (r_state == S_CHECK) && (w_state_next == S_ARM);
    w_drop_req    = (r_state == S_CHECK) && i_enable && w_full && i_overwrite && !i_rd_busy;
    w_push        = (r_state == S_CAPTURE) && i_frame_written;
    w_timeout     = (r_state == S_CAPTURE) && !i_frame_written && w_timer_last;
    o_busy        = (r_state != S_IDLE);
    o_rd_avail    = (w_count != '0);
    o_frame_count = w_count;
    o_trigger     = r_trigger;
    o_start_addr  = r_start_addr;
    o_timeout_err = r_timeout_err;
  end

  // start_addr is loaded on entry to S_ARM so it is settled a cycle before the trigger.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_trigger     <= 1'b0;
      r_start_addr  <= BASE_ADDR;
      r_timer       <= '0;
      r_pending     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_trigger <= (r_state == S_ARM);
      if (w_enter_arm) begin
        r_start_addr <= w_wr_addr;
      end
      if (r_state == S_ARM) begin
        r_timer <= '0;
      end else if (r_state == S_CAPTURE) begin
        r_timer <= r_timer + 32'd1;
      end
      if (!i_enable || w_enter_arm) begin
        r_pending <= 1'b0;
      end else if (i_capture_req && (r_state != S_ARM)) begin
        r_pending <= 1'b1;
      end
      if (!i_enable) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Randomized bench for frame_slot_scheduler against a queue-based model of the slot ring.
module tb_frame_slot_scheduler;

  localparam int          N   = 4;
  localparam logic [29:0] FB  = 30'h0080_0000;
  localparam int          TMO = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, continuous = 1'b0, overwrite = 1'b0, capture_req = 1'b0;
  logic        frame_written = 1'b0, rd_busy = 1'b0, rd_done = 1'b0;
  logic        trigger, rd_avail, timeout_err, busy;
  logic [29:0] start_addr, rd_addr;
  logic [4:0]  frame_count;
  logic [15:0] dropped_count;

  int n_total = 0;
  int n_bad   = 0;
  int q[$];
  int wr_idx  = 0;
  int dropped = 0;

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  frame_slot_scheduler #(
    .NUM_SLOTS      (N),
    .ADDR_W         (30),
    .BASE_ADDR      (30'h0),
    .FRAME_BYTES    (FB),
    .TIMEOUT_CYCLES (32'(TMO))
  ) u_dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_enable        (enable),
    .i_continuous    (continuous),
    .i_overwrite     (overwrite),
    .i_capture_req   (capture_req),
    .o_trigger       (trigger),
    .o_start_addr    (start_addr),
    .i_frame_written (frame_written),
    .o_rd_avail      (rd_avail),
    .o_rd_addr       (rd_addr),
    .i_rd_busy       (rd_busy),
    .i_rd_done       (rd_done),
    .o_frame_count   (frame_count),
    .o_dropped_count (dropped_count),
    .o_timeout_err   (timeout_err),
    .o_busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot_addr(input int slot);
    return slot * 32'(FB);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string where);
    int rd_slot;
    rd_slot = (q.size() != 0) ? q[0] : wr_idx;
    check({where, ".frame_count"}, 32'(frame_count), q.size());
    check({where, ".rd_avail"}, 32'(rd_avail), (q.size() != 0) ? 1 : 0);
    check({where, ".rd_addr"}, 32'(rd_addr), slot_addr(rd_slot));
    check({where, ".dropped"}, 32'(dropped_count), dropped);
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_commit(input bit with_rd);
    frame_written = 1'b1;
    if (with_rd && q.size() != 0) begin
      rd_done = 1'b1;
      void'(q.pop_front());
    end
    tick();
    frame_written = 1'b0;
    rd_done       = 1'b0;
    q.push_back(wr_idx);
    wr_idx = (wr_idx + 1) % N;
  endtask

  task automatic wait_trigger(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (trigger) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr_idx  = 0;
    dropped = 0;
  endtask

  initial begin
    bit got;
    int ntrig;
    bit ov, hb;

    // Reset values
    tick();
    check("rst.trigger", 32'(trigger), 0);
    check("rst.start_addr", 32'(start_addr), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.timeout_err", 32'(timeout_err), 0);
    check_model("rst");
    reset_n = 1'b1;
    tick();

    // Continuous fill without readout: stall when full, resume on rd_done
    enable = 1'b1;
    continuous = 1'b1;
    for (int k = 0; k < N; k++) begin
      wait_trigger(20, got);
      check("cont.trig_seen", 32'(got), 1);
      check("cont.start_addr", 32'(start_addr), slot_addr(wr_idx));
      repeat (3) tick();
      do_commit(1'b0);
    end
    ntrig = 0;
    repeat (30) begin
      tick();
      ntrig += int'(trigger);
    end
    check("cont.no_5th_trig", ntrig, 0);
    check("cont.stalled_busy", 32'(busy), 1);
    check_model("cont.full");
    pulse_rd_done();
    wait_trigger(20, got);
    check("cont.resume_trig", 32'(got), 1);
    check("cont.wrap_start", 32'(start_addr), slot_addr(0));
    check("cont.wrap_rd_addr", 32'(rd_addr), 32'(FB));
    continuous = 1'b0;
    repeat (3) tick();
    do_commit(1'b0);
    check("cont.idle", 32'(busy), 0);
    check_model("cont.end");

    // Reset while a capture is in flight with three frames stored
    pulse_rd_done();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    wait_trigger(20, got);
    check("rstcap.trig_seen", 32'(got), 1);
    check("rstcap.count", 32'(frame_count), 3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rstcap.trigger", 32'(trigger), 0);
    check("rstcap.start_addr", 32'(start_addr), 0);
    check("rstcap.busy", 32'(busy), 0);
    check_model("rstcap.async");
    tick();
    reset_n = 1'b1;
    tick();
    do_commit(1'b0);
    void'(q.pop_back());
    wr_idx = 0;
    check("rstcap.fw_ignored_busy", 32'(busy), 0);
    check_model("rstcap.fw_ignored");

    // Randomized single-shot captures with drops, stalls, timeouts and readouts
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) pulse_rd_done();
      ov = 1'($urandom_range(0, 1));
      hb = ($urandom_range(0, 2) == 0);
      overwrite = ov;
      rd_busy   = hb;
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
      if (q.size() == N) begin
        if (ov && !hb) begin
          void'(q.pop_front());
          dropped++;
        end else begin
          ntrig = 0;
          repeat (15) begin
            tick();
            ntrig += int'(trigger);
          end
          check("rnd.stall_no_trig", ntrig, 0);
          check("rnd.stall_dropped", 32'(dropped_count), dropped);
          pulse_rd_done();
          rd_busy = 1'b0;
        end
      end
      wait_trigger(20, got);
      check("rnd.trig_seen", 32'(got), 1);
      check("rnd.start_addr", 32'(start_addr), slot_addr(wr_idx));
      if (it % 7 == 3) begin
        repeat (TMO - 1) tick();
        check("rnd.tmo_early", 32'(timeout_err), 0);
        tick();
        check("rnd.tmo_flag", 32'(timeout_err), 1);
        check("rnd.tmo_idle", 32'(busy), 0);
        check_model("rnd.tmo");
        enable = 1'b0;
        tick();
        check("rnd.tmo_clear", 32'(timeout_err), 0);
        enable = 1'b1;
      end else begin
        repeat ($urandom_range(1, 12)) tick();
        do_commit($urandom_range(0, 2) == 0);
        check("rnd.idle", 32'(busy), 0);
        check_model("rnd.commit");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
